sc_mm_mem_ctrl: RTL and testbench

SC_MM_MEM_CTRL -- requirements
Module: sc_mm_mem_ctrl

---
 rtl/sc_mm_mem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_sc_mm_mem_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sc_mm_mem_ctrl.sv
// sc_mm_mem_ctrl: memory-side sequencer for a stochastic-computing matrix
// multiply wrapper. A start request loads an M x N input matrix and an O x N
// weight matrix from word memory into packed operand registers, enables the
// wrapper, captures its M x O result and writes it back to memory.
//
// Ports
//   clk, rst            clock (posedge), synchronous active-high reset
//   start               one-cycle run request, accepted only in IDLE
//   in_base/w_base/out_base  base word addresses, sampled on accepted start
//   mem_rd_*            read port; mem_rd_data valid the cycle after mem_rd_en
//   mem_wr_*            write port
//   input_matrix        word k = m*N+n ; weight_matrix word k = o*N+n
//   mm_enable / mm_result / mm_result_valid   wrapper handshake
//   busy                high outside IDLE ; done  one-cycle completion pulse
module sc_mm_mem_ctrl #(
  parameter int BATCH_SIZE       = 4,
  parameter int INPUT_FEATURES   = 4,
  parameter int OUTPUT_FEATURES  = 4,
  parameter int BINARY_PRECISION = 32,
  parameter int ADDR_WIDTH       = 16
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    start,
  input  logic [ADDR_WIDTH-1:0]                                   in_base,
  input  logic [ADDR_WIDTH-1:0]                                   w_base,
  input  logic [ADDR_WIDTH-1:0]                                   out_base,
  output logic                                                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                                   mem_rd_addr,
  input  logic [BINARY_PRECISION-1:0]                             mem_rd_data,
  output logic                                                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]                                   mem_wr_addr,
  output logic [BINARY_PRECISION-1:0]                             mem_wr_data,
  output logic [BINARY_PRECISION*BATCH_SIZE*INPUT_FEATURES-1:0]   input_matrix,
  output logic [BINARY_PRECISION*OUTPUT_FEATURES*INPUT_FEATURES-1:0] weight_matrix,
  output logic                                                    mm_enable,
  input  logic [BINARY_PRECISION*BATCH_SIZE*OUTPUT_FEATURES-1:0]  mm_result,
  input  logic                                                    mm_result_valid,
  output logic                                                    busy,
  output logic                                                    done
);
  localparam int BP        = BINARY_PRECISION;
  localparam int AW        = ADDR_WIDTH;
  localparam int IN_WORDS  = BATCH_SIZE * INPUT_FEATURES;
  localparam int W_WORDS   = OUTPUT_FEATURES * INPUT_FEATURES;
  localparam int OUT_WORDS = BATCH_SIZE * OUTPUT_FEATURES;
  localparam int MAX_A     = (IN_WORDS > W_WORDS) ? IN_WORDS : W_WORDS;
  localparam int MAX_WORDS = (MAX_A > OUT_WORDS) ? MAX_A : OUT_WORDS;
  localparam int KW        = $clog2(MAX_WORDS + 1);

  localparam logic [KW-1:0] IN_LAST  = KW'(IN_WORDS - 1);
  localparam logic [KW-1:0] W_LAST   = KW'(W_WORDS - 1);
  localparam logic [KW-1:0] OUT_LAST = KW'(OUT_WORDS - 1);
  localparam logic [KW-1:0] K_ONE    = KW'(1);
  localparam logic [AW-1:0] A_ONE    = AW'(1);

  typedef enum logic [2:0] {IDLE, RD_IN, RD_W, DRAIN, RUN, WR, DONE} state_t;

  state_t                      state;
  logic [KW-1:0]               k;          // word index of the current read/write
  logic [AW-1:0]               w_base_r;
  logic [AW-1:0]               out_base_r;
  // Read-return tracking: the word arriving on mem_rd_data this cycle
  logic                        cap_vld;
  logic                        cap_w;
  logic [KW-1:0]               cap_k;
  // Result buffer holds the words not yet written; it shifts down one word
  // per write so the next word is always at the bottom.
  logic [BP*OUT_WORDS-1:0]     res_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      w_base_r    <= '0;
      out_base_r  <= '0;
      cap_vld     <= 1'b0;
      cap_w       <= 1'b0;
      cap_k       <= '0;
      res_buf     <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mm_enable   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      cap_vld <= mem_rd_en;
      cap_w   <= (state == RD_W);
      cap_k   <= k;
      done    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state       <= RD_IN;
          busy        <= 1'b1;
          mem_rd_en   <= 1'b1;
          mem_rd_addr <= in_base;
          w_base_r    <= w_base;
          out_base_r  <= out_base;
          k           <= '0;
        end
        RD_IN: if (k == IN_LAST) begin
          state       <= RD_W;
          k           <= '0;
          mem_rd_addr <= w_base_r;
        end else begin
          k           <= k + K_ONE;
          mem_rd_addr <= mem_rd_addr + A_ONE;
        end
        RD_W: if (k == W_LAST) begin
          state     <= DRAIN;
          mem_rd_en <= 1'b0;
        end else begin
          k           <= k + K_ONE;
          mem_rd_addr <= mem_rd_addr + A_ONE;
        end
        // Last weight word lands this cycle (captured via cap_vld below)
        DRAIN: begin
          state     <= RUN;
          mm_enable <= 1'b1;
        end
        RUN: if (mm_result_valid) begin
          state       <= WR;
          mm_enable   <= 1'b0;
          res_buf     <= mm_result >> BP;
          mem_wr_en   <= 1'b1;
          mem_wr_addr <= out_base_r;
          mem_wr_data <= mm_result[BP-1:0];
          k           <= '0;
        end
        WR: if (k == OUT_LAST) begin
          state     <= DONE;
          mem_wr_en <= 1'b0;
          done      <= 1'b1;
        end else begin
          k           <= k + K_ONE;
          mem_wr_addr <= mem_wr_addr + A_ONE;
          mem_wr_data <= res_buf[BP-1:0];
          res_buf     <= res_buf >> BP;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture: one register slice per word, loaded when its read returns.
  // Slices keep their value until the next load overwrites them.
  for (genvar g = 0; g < IN_WORDS; g++) begin : g_in
    always_ff @(posedge clk) begin
      if (rst) input_matrix[g*BP +: BP] <= '0;
      else if (cap_vld && !cap_w && cap_k == KW'(g)) input_matrix[g*BP +: BP] <= mem_rd_data;
    end
  end

  for (genvar g = 0; g < W_WORDS; g++) begin : g_w
    always_ff @(posedge clk) begin
      if (rst) weight_matrix[g*BP +: BP] <= '0;
      else if (cap_vld && cap_w && cap_k == KW'(g)) weight_matrix[g*BP +: BP] <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_sc_mm_mem_ctrl.sv
module tb_sc_mm_mem_ctrl;
  localparam int M = 4, N = 4, O = 4, BP = 32, AW = 16;
  localparam int NIN = M * N, NW = O * N, NOUT = M * O;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [AW-1:0]     in_base = '0, w_base = '0, out_base = '0;
  logic              mem_rd_en, mem_wr_en;
  logic [AW-1:0]     mem_rd_addr, mem_wr_addr;
  logic [BP-1:0]     mem_rd_data = '0;
  logic [BP-1:0]     mem_wr_data;
  logic [BP*NIN-1:0] input_matrix;
  logic [BP*NW-1:0]  weight_matrix;
  logic              mm_enable;
  logic [BP*NOUT-1:0] mm_result = '0;
  logic              mm_result_valid = 1'b0;
  logic              busy, done;

  sc_mm_mem_ctrl #(
    .BATCH_SIZE(M), .INPUT_FEATURES(N), .OUTPUT_FEATURES(O),
    .BINARY_PRECISION(BP), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_base(in_base), .w_base(w_base), .out_base(out_base),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .input_matrix(input_matrix), .weight_matrix(weight_matrix),
    .mm_enable(mm_enable), .mm_result(mm_result), .mm_result_valid(mm_result_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Word memory with a one-cycle read latency
  logic [BP-1:0] mem [0:65535];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  // Bus monitor
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wa_q[$];
  logic [BP-1:0] wd_q[$];
  int            wc_q[$];
  int            done_q[$];
  int            both_cnt = 0;
  always @(negedge clk) begin
    if (mem_rd_en) rd_q.push_back(mem_rd_addr);
    if (mem_wr_en) begin
      wa_q.push_back(mem_wr_addr);
      wd_q.push_back(mem_wr_data);
      wc_q.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
    if (mem_rd_en && mem_wr_en) both_cnt = both_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // One complete operation. dly = RUN cycles before valid; inj pulses start in
  // RD_W and WR; early pulses a bogus valid in RD_IN; rst_at > 0 resets on that
  // WR cycle.
  task automatic do_op(input string nm, input logic [AW-1:0] in_b, input logic [AW-1:0] w_b,
                       input logic [AW-1:0] out_b, input logic [BP*NOUT-1:0] res,
                       input int dly, input bit inj, input bit early, input int rst_at);
    logic [BP*NIN-1:0] ein;
    logic [BP*NW-1:0]  ew;
    logic [BP*NOUT-1:0] t;
    logic [AW-1:0]     a;
    int c0, en_rel, tv, nwr;
    ein = '0; ew = '0;
    for (int k = 0; k < NIN; k++) begin a = in_b + AW'(k); ein = {mem[a], ein[BP*NIN-1:BP]}; end
    for (int k = 0; k < NW; k++)  begin a = w_b + AW'(k);  ew  = {mem[a], ew[BP*NW-1:BP]}; end
    rd_q.delete(); wa_q.delete(); wd_q.delete(); wc_q.delete(); done_q.delete();

    @(negedge clk);
    start = 1'b1; in_base = in_b; w_base = w_b; out_base = out_b; c0 = cyc;
    en_rel = -1;
    for (int i = 1; i <= 60 && en_rel < 0; i++) begin
      @(negedge clk);
      start = inj && (cyc - c0 == 20);
      if (early && (cyc - c0 == 3)) begin mm_result = ~res; mm_result_valid = 1'b1; end
      else mm_result_valid = 1'b0;
      if (mm_enable) en_rel = cyc - c0;
    end
    start = 1'b0;
    chk({nm, " enable_cycle"}, 512'(en_rel), 512'(34));
    chk({nm, " input_matrix"}, 512'(input_matrix), 512'(ein));
    chk({nm, " weight_matrix"}, 512'(weight_matrix), 512'(ew));

    repeat (dly) @(negedge clk);
    chk({nm, " enable_held"}, 512'(mm_enable), 512'(1));
    mm_result = res; mm_result_valid = 1'b1; tv = cyc;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      mm_result_valid = 1'b0;
      mm_result = ~res;
      start = inj && (i == 3);
      if (i == 1) chk({nm, " enable_drop"}, 512'(mm_enable), 512'(0));
      if (rst_at > 0 && i == rst_at) rst = 1'b1;
      if (rst_at > 0 && i == rst_at + 1) begin
        rst = 1'b0;
        chk({nm, " rst_wr_en"}, 512'(mem_wr_en), 512'(0));
        chk({nm, " rst_busy"}, 512'(busy), 512'(0));
        chk({nm, " rst_enable"}, 512'(mm_enable), 512'(0));
        chk({nm, " rst_addrs"}, 512'({mem_rd_addr, mem_wr_addr, mem_wr_data}), 512'(0));
        chk({nm, " rst_matrices"}, 512'(input_matrix | weight_matrix), 512'(0));
      end
    end
    start = 1'b0;

    chk({nm, " rd_count"}, 512'(rd_q.size()), 512'(NIN + NW));
    for (int i = 0; i < NIN + NW && i < rd_q.size(); i++) begin
      a = (i < NIN) ? in_b + AW'(i) : w_b + AW'(i - NIN);
      chk($sformatf("%s rd_addr%0d", nm, i), 512'(rd_q[i]), 512'(a));
    end
    nwr = (rst_at > 0) ? rst_at : NOUT;
    chk({nm, " wr_count"}, 512'(wa_q.size()), 512'(nwr));
    t = res;
    for (int i = 0; i < nwr && i < wa_q.size(); i++) begin
      a = out_b + AW'(i);
      chk($sformatf("%s wr_addr%0d", nm, i), 512'(wa_q[i]), 512'(a));
      chk($sformatf("%s wr_data%0d", nm, i), 512'(wd_q[i]), 512'(t[BP-1:0]));
      t = t >> BP;
    end
    if (wc_q.size() > 0) chk({nm, " first_wr_cycle"}, 512'(wc_q[0]), 512'(tv + 1));
    else chk({nm, " first_wr_cycle"}, 512'(-1), 512'(tv + 1));
    chk({nm, " done_count"}, 512'(done_q.size()), 512'((rst_at > 0) ? 0 : 1));
    if (rst_at == 0 && done_q.size() > 0)
      chk({nm, " done_cycle"}, 512'(done_q[0]), 512'(tv + 17));
    chk({nm, " idle_busy"}, 512'(busy), 512'(0));
    chk({nm, " rd_wr_overlap"}, 512'(both_cnt), 512'(0));
  endtask

  function automatic logic [BP*NOUT-1:0] rand_res();
    logic [BP*NOUT-1:0] r;
    r = '0;
    for (int k = 0; k < NOUT; k++) r = {$urandom(), r[BP*NOUT-1:BP]};
    return r;
  endfunction

  initial begin
    logic [BP*NOUT-1:0] res;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom();
    for (int i = 0; i < 16; i++) begin
      mem[16'h0100 + i] = BP'(i + 1);
      mem[16'h0200 + i] = BP'(32'h11 + i);
    end

    // Reset with start held high: reset wins
    rst = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 512'({busy, done, mm_enable, mem_rd_en, mem_wr_en}), 512'(0));
    chk("reset_addrs", 512'({mem_rd_addr, mem_wr_addr, mem_wr_data}), 512'(0));
    chk("reset_matrices", 512'(input_matrix | weight_matrix), 512'(0));
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("reset_start_ignored", 512'(busy), 512'(0));

    // Directed load/writeback with result words 0xA0+k, valid on 3rd RUN cycle
    res = '0;
    for (int k = 0; k < NOUT; k++) res = {BP'(32'hA0 + k), res[BP*NOUT-1:BP]};
    do_op("directed", 16'h0100, 16'h0200, 16'h0300, res, 2, 1'b0, 1'b0, 0);
    chk("directed_in_w0", 512'(input_matrix[BP-1:0]), 512'(1));
    chk("directed_w_w15", 512'(weight_matrix[BP*NW-1 -: BP]), 512'(32'h20));

    // Address wrap of the input read window
    do_op("wrap", 16'hFFFE, 16'(($urandom() & 32'h7FFF)), 16'hFFF8, rand_res(), 0, 1'b0, 1'b0, 0);

    // Start pulses during RD_W and WR are ignored
    do_op("start_inj", 16'($urandom()), 16'($urandom()), 16'($urandom()), rand_res(), 1, 1'b1, 1'b0, 0);

    // Stray valid during RD_IN is ignored
    do_op("early_valid", 16'($urandom()), 16'($urandom()), 16'($urandom()), rand_res(), 3, 1'b0, 1'b1, 0);

    // Reset on 5th WR cycle, then a normal operation
    do_op("rst_abort", 16'($urandom()), 16'($urandom()), 16'($urandom()), rand_res(), 1, 1'b0, 1'b0, 5);
    do_op("after_rst", 16'($urandom()), 16'($urandom()), 16'($urandom()), rand_res(), 0, 1'b0, 1'b0, 0);

    // Randomized operations
    for (int r = 0; r < 4; r++)
      do_op($sformatf("rand%0d", r), 16'($urandom()), 16'($urandom()), 16'($urandom()),
            rand_res(), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
